// File: rtl/demux1b16_buf_pkg.sv
// rtl/demux1b16_buf_pkg.sv - shared constants and occupancy encoding for demux1b16_buf
package demux1b16_buf_pkg;

  localparam int DATA_W = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Per-channel occupancy encoding, kept in a register for debug visibility
  localparam logic [1:0] OCC_EMPTY   = 2'd0;
  localparam logic [1:0] OCC_PARTIAL = 2'd1;
  localparam logic [1:0] OCC_FULL    = 2'd2;

  function automatic logic [1:0] occ_of(input int cnt, input int depth);
    if (cnt == 0) begin
      occ_of = OCC_EMPTY;
    end else if (cnt >= depth) begin
      occ_of = OCC_FULL;
    end else begin
      occ_of = OCC_PARTIAL;
    end
  endfunction

endpackage

// File: rtl/demux1b16_buf_chan_fifo.sv
// rtl/demux1b16_buf_chan_fifo.sv - per-channel FIFO (module demux_chan_fifo), registered full/valid
module demux_chan_fifo
  import demux1b16_buf_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PushEn,
  input  logic [WIDTH-1:0] PushData,
  output logic             Full,
  input  logic             PopEn,
  output logic [WIDTH-1:0] Data,
  output logic             Valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_n;
  logic [1:0]       occ;
  logic             push;
  logic             pop;

  // Full/Valid come straight from the occupancy register, so no ready path is combinational
  assign Full  = (occ == OCC_FULL);
  assign Valid = (occ != OCC_EMPTY);
  assign Data  = mem[rd_ptr];

  assign push = PushEn & ~Full;
  assign pop  = PopEn & Valid;

  always_comb begin
    count_n = count;
    if (push && !pop) begin
      count_n = count + CW'(1);
    end else if (pop && !push) begin
      count_n = count - CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      occ    <= OCC_EMPTY;
    end else begin
      if (push) begin
        mem[wr_ptr] <= PushData;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_n;
      occ   <= occ_of(int'(count_n), DEPTH);
    end
  end

endmodule

// File: rtl/demux1b16_buf.sv
// rtl/demux1b16_buf.sv - buffered 1-to-2 demux with per-channel FIFOs
// Optional per-channel route counters (CountA/CountB) under DEMUX_ROUTE_COUNT_EN.
module demux1b16_buf
  import demux1b16_buf_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In,
  input  logic             Sel,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] OutA,
  output logic             OutAValid,
  input  logic             OutAReady,
  output logic [WIDTH-1:0] OutB,
  output logic             OutBValid,
`ifdef DEMUX_ROUTE_COUNT_EN
  input  logic             OutBReady,
  output logic [15:0]      CountA,
  output logic [15:0]      CountB
`else
  input  logic             OutBReady
`endif
);

  logic full_a;
  logic full_b;
  logic push_a;
  logic push_b;

  // InReady depends only on Sel and the registered full flags
  assign InReady = (Sel == SEL_B) ? ~full_b : ~full_a;
  assign push_a  = InValid & InReady & (Sel == SEL_A);
  assign push_b  = InValid & InReady & (Sel == SEL_B);

  demux_chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .CLK      (CLK),
    .Reset    (Reset),
    .PushEn   (push_a),
    .PushData (In),
    .Full     (full_a),
    .PopEn    (OutAReady),
    .Data     (OutA),
    .Valid    (OutAValid)
  );

  demux_chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .CLK      (CLK),
    .Reset    (Reset),
    .PushEn   (push_b),
    .PushData (In),
    .Full     (full_b),
    .PopEn    (OutBReady),
    .Data     (OutB),
    .Valid    (OutBValid)
  );

`ifdef DEMUX_ROUTE_COUNT_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      CountA <= 16'd0;
      CountB <= 16'd0;
    end else begin
      if (push_a) begin
        CountA <= CountA + 16'd1;
      end
      if (push_b) begin
        CountB <= CountB + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux1b16_buf.sv
// tb/tb_demux1b16_buf.sv - directed self-checking bench for demux1b16_buf
module tb_demux1b16_buf;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] In = 16'h0000;
  logic        Sel = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [15:0] OutA;
  logic        OutAValid;
  logic        OutAReady = 1'b0;
  logic [15:0] OutB;
  logic        OutBValid;
  logic        OutBReady = 1'b0;
`ifdef DEMUX_ROUTE_COUNT_EN
  logic [15:0] CountA;
  logic [15:0] CountB;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  demux1b16_buf #(.WIDTH(16), .DEPTH(2)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .In        (In),
    .Sel       (Sel),
    .InValid   (InValid),
    .InReady   (InReady),
    .OutA      (OutA),
    .OutAValid (OutAValid),
    .OutAReady (OutAReady),
    .OutB      (OutB),
    .OutBValid (OutBValid),
`ifdef DEMUX_ROUTE_COUNT_EN
    .OutBReady (OutBReady),
    .CountA    (CountA),
    .CountB    (CountB)
`else
    .OutBReady (OutBReady)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    InValid = 1'b0;
    OutAReady = 1'b0;
    OutBReady = 1'b0;
    step();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (OutAValid !== 1'b0 || OutBValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b%b exp 00", OutAValid, OutBValid); end
    checks++; if (OutA !== 16'h0000 || OutB !== 16'h0000) begin errors++; $display("FAIL reset_data got %h %h exp 0000 0000", OutA, OutB); end
    step();
    Reset = 1'b0;
    In = 16'h0008; Sel = 1'b0; InValid = 1'b1; OutAReady = 1'b0;
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready got %b exp 1", InReady); end
    step();
    checks++; if (OutAValid !== 1'b1 || OutA !== 16'h0008) begin errors++; $display("FAIL reset_prepush got %b %h exp 1 0008", OutAValid, OutA); end
    #2;
    Reset = 1'b1;
    #1;
    checks++; if (OutAValid !== 1'b0 || OutBValid !== 1'b0) begin errors++; $display("FAIL reset_midcycle got %b%b exp 00", OutAValid, OutBValid); end
    step();
    step();
    Reset = 1'b0;
    InValid = 1'b0;
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", InReady); end
    step();
    checks++; if (OutAValid !== 1'b0 || OutBValid !== 1'b0) begin errors++; $display("FAIL reset_no_emit got %b%b exp 00", OutAValid, OutBValid); end
  endtask

  task automatic test_routing();
    do_reset();
    OutAReady = 1'b1; OutBReady = 1'b1;
    In = 16'h0008; Sel = 1'b0; InValid = 1'b1;
    step();
    checks++; if (OutAValid !== 1'b1 || OutA !== 16'h0008) begin errors++; $display("FAIL route_a got %b %h exp 1 0008", OutAValid, OutA); end
    checks++; if (OutBValid !== 1'b0) begin errors++; $display("FAIL route_a_leak got %b exp 0", OutBValid); end
    In = 16'h0004; Sel = 1'b1;
    step();
    checks++; if (OutBValid !== 1'b1 || OutB !== 16'h0004) begin errors++; $display("FAIL route_b got %b %h exp 1 0004", OutBValid, OutB); end
    checks++; if (OutAValid !== 1'b0) begin errors++; $display("FAIL route_b_leak got %b exp 0", OutAValid); end
    InValid = 1'b0;
    step();
    checks++; if (OutBValid !== 1'b0) begin errors++; $display("FAIL route_b_drain got %b exp 0", OutBValid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    OutAReady = 1'b0; OutBReady = 1'b1;
    Sel = 1'b0; InValid = 1'b1; In = 16'h0001;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", InReady); end
    step();
    In = 16'h0002;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL bp_ready2 got %b exp 1", InReady); end
    step();
    In = 16'h0003;
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL bp_full got %b exp 0", InReady); end
    step();
    checks++; if (InReady !== 1'b0 || OutA !== 16'h0001) begin errors++; $display("FAIL bp_held got %b %h exp 0 0001", InReady, OutA); end
    OutAReady = 1'b1;
    #1;
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL bp_no_comb_ready got %b exp 0", InReady); end
    step();
    checks++; if (OutAValid !== 1'b1 || OutA !== 16'h0002 || InReady !== 1'b1) begin errors++; $display("FAIL bp_order2 got %b %h %b exp 1 0002 1", OutAValid, OutA, InReady); end
    step();
    InValid = 1'b0;
    checks++; if (OutAValid !== 1'b1 || OutA !== 16'h0003) begin errors++; $display("FAIL bp_order3 got %b %h exp 1 0003", OutAValid, OutA); end
    step();
    checks++; if (OutAValid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", OutAValid); end
  endtask

  task automatic test_isolation();
    do_reset();
    OutAReady = 1'b0; OutBReady = 1'b0;
    Sel = 1'b0; InValid = 1'b1; In = 16'h00A1;
    step();
    In = 16'h00A2;
    step();
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL iso_a_full got %b exp 0", InReady); end
    Sel = 1'b1; In = 16'h00BB;
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL iso_b_ready got %b exp 1", InReady); end
    step();
    InValid = 1'b0;
    checks++; if (OutBValid !== 1'b1 || OutB !== 16'h00BB) begin errors++; $display("FAIL iso_b_out got %b %h exp 1 00BB", OutBValid, OutB); end
    Sel = 1'b0;
    #1;
    checks++; if (InReady !== 1'b0 || OutAValid !== 1'b1 || OutA !== 16'h00A1) begin errors++; $display("FAIL iso_a_stays got %b %b %h exp 0 1 00A1", InReady, OutAValid, OutA); end
    OutAReady = 1'b1; OutBReady = 1'b1;
    step();
    checks++; if (OutA !== 16'h00A2 || OutBValid !== 1'b0) begin errors++; $display("FAIL iso_drain got %h %b exp 00A2 0", OutA, OutBValid); end
    step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    OutBReady = 1'b0; OutAReady = 1'b1;
    Sel = 1'b1; InValid = 1'b1; In = 16'h0044;
    step();
    OutBReady = 1'b1; In = 16'h0055;
    #1;
    checks++; if (OutBValid !== 1'b1 || OutB !== 16'h0044) begin errors++; $display("FAIL simul_head got %b %h exp 1 0044", OutBValid, OutB); end
    step();
    InValid = 1'b0;
    checks++; if (OutBValid !== 1'b1 || OutB !== 16'h0055 || InReady !== 1'b1) begin errors++; $display("FAIL simul_next got %b %h %b exp 1 0055 1", OutBValid, OutB, InReady); end
    step();
    checks++; if (OutBValid !== 1'b0) begin errors++; $display("FAIL simul_empty got %b exp 0", OutBValid); end
  endtask

`ifdef DEMUX_ROUTE_COUNT_EN
  task automatic test_counters();
    do_reset();
    OutAReady = 1'b1; OutBReady = 1'b1; InValid = 1'b1;
    checks++; if (CountA !== 16'd0 || CountB !== 16'd0) begin errors++; $display("FAIL cnt_reset got %0d %0d exp 0 0", CountA, CountB); end
    Sel = 1'b0;
    for (int i = 0; i < 5; i++) begin In = 16'(i); step(); end
    Sel = 1'b1;
    for (int i = 0; i < 3; i++) begin In = 16'(i); step(); end
    InValid = 1'b0;
    checks++; if (CountA !== 16'd5 || CountB !== 16'd3) begin errors++; $display("FAIL cnt_routes got %0d %0d exp 5 3", CountA, CountB); end
    do_reset();
    OutAReady = 1'b1; OutBReady = 1'b1; InValid = 1'b1; Sel = 1'b0;
    for (int i = 0; i < 65536; i++) begin step(); end
    InValid = 1'b0;
    checks++; if (CountA !== 16'd0 || CountB !== 16'd0) begin errors++; $display("FAIL cnt_wrap got %0d %0d exp 0 0", CountA, CountB); end
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_isolation();
    test_simultaneous();
`ifdef DEMUX_ROUTE_COUNT_EN
    test_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
